rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter with a hold timeout. Shares one resource among four clients: the write port of the 4-entry register bank selected by the 2-to-4 decoder. It latches a winner, holds the grant while that requester keeps its request high, and forces release after a configurable number of cycles. The one-hot grant comes from the encoded winner ID through `decoder2_4`, enabled only while a grant is active.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per tenure. 0 means unlimited. Legal range 0–255.
- `DELAY`, default 50: gate delay in ps, passed to the `decoder2_4` instance.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  input  4  request vector; bit i is requester i.
- `gnt`  output  4  one-hot grant, all zeros when idle.
- `gnt_id`  output  2  encoded current winner; 0 when idle.
- `busy`  output  1  grant active; this is the decoder enable.
- `timeout`  output  1  one-cycle pulse when a tenure is force-ended by `MAX_HOLD`.

## Operation
- State register: `IDLE`, `GRANT`.
- Other registers: `ptr[1:0]` (next priority start), `id_q[1:0]`, `hold_cnt[7:0]`, `timeout_q`.
- Arbitration function: scan `req` starting at `ptr`, then `ptr+1`, … mod 4, with an optional mask. The first set bit wins.
- **IDLE**
  - If any `req` is set: latch the winner into `id_q`, set `hold_cnt` = 0, go to `GRANT`.
  - Otherwise stay in `IDLE`.
- **GRANT**, release condition: `req[id_q]` = 0, or (`MAX_HOLD` ≠ 0 and `hold_cnt` = `MAX_HOLD`−1 and `req[id_q]` = 1).
  - No release: `hold_cnt` increments; it saturates at 255 when `MAX_HOLD` = 0.
  - On release: `ptr` ← `id_q`+1 (mod 4). Re-arbitrate from that new `ptr`, with `req[id_q]` masked.
  - If the masked arbitration finds a winner: grant it back-to-back with no idle cycle, set `hold_cnt` = 0, stay in `GRANT`.
  - If it finds no winner: go to `IDLE`.
  - `timeout_q` = 1 for exactly the cycle after a forced release; 0 otherwise.
- Output mapping: `busy` = (state == `GRANT`), `gnt_id` = `busy` ? `id_q` : 0, `gnt` = `decoder2_4(gnt_id, busy)`.
  - `gnt` is never more than one-hot.
- A timed-out requester that keeps `req` high is re-granted only after the other requesters are served. If it is the sole requester, it is re-granted after one `IDLE` cycle.
- `req` changes on non-winning bits during `GRANT` have no effect until the next release.

## Timing
- Reset (`reset_n` = 0 at an edge): state `IDLE`, `ptr` = 0, `id_q` = 0, `hold_cnt` = 0, `timeout_q` = 0. As a result `gnt` = 0, `gnt_id` = 0, `busy` = 0, `timeout` = 0.
- Reset asserted mid-grant: grant drops at that edge, with no `timeout` pulse. After reset, priority restarts at requester 0.
- Request-to-grant latency: `req` sampled at edge N gives `busy`/`gnt_id` valid after edge N, i.e. during cycle N+1.
  - `gnt` settles 2×`DELAY` ps later (inverter plus AND).
  - The clock period must exceed 2×`DELAY` plus the consumer's setup time.
- Release-to-next-grant latency: 0 idle cycles when another request is pending at the release edge.
- Maximum tenure: exactly `MAX_HOLD` cycles of `busy` for one requester.
- Starvation bound: every set request is granted within 3×`MAX_HOLD`+4 cycles when `MAX_HOLD` ≠ 0.
- Simultaneous events at the same edge:
  - `req` drop and `MAX_HOLD` expiry together: treat as a normal release, no `timeout`.
  - `reset_n` = 0 overrides everything.

## Structure
- Shared package `arb_pkg`:
  - `typedef enum logic {IDLE, GRANT} arb_state_t`.
  - `localparam NREQ = 4`, `localparam IDW = 2`.
  - Function `rr_pick(req, ptr, mask)` returning a valid flag and an ID.
- One sub-module: the existing `decoder2_4`, with `in` = `gnt_id`, `e` = `busy`, and `delay` = `DELAY`.
- Sequential logic in a single `always_ff` block; next-state logic in `always_comb`.

## Test plan
- Reset, then `req` = 4'b0000 for 5 cycles → `gnt` = 0, `busy` = 0, `timeout` = 0 throughout.
- `req` = 4'b1010 held, with each winner dropping its `req` after 3 cycles of `gnt` and re-raising it 1 cycle later → `gnt` sequence 0010, 1000, 0010. Each tenure lasts 3 cycles and grants are back-to-back with no idle gap.
- `MAX_HOLD` = 4, `req` = 4'b0001 held high → `gnt` = 0001 for 4 cycles, `timeout` = 1 for 1 cycle, 1 `IDLE` cycle, then `gnt` = 0001 again.
- `MAX_HOLD` = 4, `req` = 4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001, 4 cycles each, with a `timeout` pulse after each tenure.
- `req[2]` drops in the same cycle that `hold_cnt` reaches `MAX_HOLD`−1, with `req` = 4'b0100 → release, `timeout` = 0, then `IDLE`.
- `reset_n` driven low during the 2nd cycle of a grant to requester 3 → `gnt` = 0 after that edge. On release of reset with `req` = 4'b1001, requester 0 wins.

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : arb_pkg
// Description : Shared types, sizes and the round-robin pick function for the
//               four-requester arbiter.
//               - arb_state_t : arbiter FSM states (IDLE, GRANT)
//               - NREQ / IDW  : requester count and encoded-ID width
//               - pick_t      : result of a round-robin scan (valid + id)
//               - rr_pick()   : scan req from ptr upward (mod NREQ), skipping
//                               masked bits; first set bit wins
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } pick_t;

  // Offsets are visited from the farthest to the nearest so that the last
  // hit written is the one closest to ptr; this avoids an early loop exit.
  function automatic pick_t rr_pick(
    input logic [NREQ-1:0] req,
    input logic [IDW-1:0]  ptr,
    input logic [NREQ-1:0] mask
  );
    pick_t           res;
    logic [NREQ-1:0] elig;
    logic [IDW-1:0]  idx;
    res  = '0;
    elig = req & ~mask;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDW'(k);
      if (elig[idx]) begin
        res.valid = 1'b1;
        res.id    = idx;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rr_arbiter4_if
// Description : Request/grant bundle between the clients and the arbiter.
//               req     : request vector, bit i is requester i
//               gnt     : one-hot grant, zero when idle
//               gnt_id  : encoded current winner, zero when idle
//               busy    : a grant is active
//               timeout : one-cycle pulse after a forced release
//               modport master : client side (drives req)
//               modport slave  : arbiter side (drives the grant signals)
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter4_decoder2_4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : decoder2_4
// Description : 2-to-4 decoder with enable, built as input inverters feeding
//               one AND term per output.
//               delay : gate delay in ps of the modelled cells (inverter and
//                       AND); it sets the settle budget of y after in/e move
//                       but adds no behaviour to the synthesised logic
//               in    : 2-bit select
//               e     : enable; y is all zeros while low
//               y     : one-hot output
// Revision    : 1.0 - initial release
// ============================================================================
module decoder2_4 #(
  parameter int delay = 50
) (
  input  logic [1:0] in,
  input  logic       e,
  output logic [3:0] y
);

  if (delay < 0) begin : g_bad_delay
    $error("decoder2_4: delay must be non-negative");
  end

  logic [1:0] in_n;

  assign in_n = ~in;

  for (genvar i = 0; i < 4; i++) begin : g_out
    localparam logic [1:0] c_CODE = 2'(i);
    assign y[i] = e
                & (c_CODE[1] ? in[1] : in_n[1])
                & (c_CODE[0] ? in[0] : in_n[0]);
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester round-robin arbiter with a hold timeout.
//               A winner keeps the grant while its request stays high, up to
//               MAX_HOLD consecutive cycles (0 = unlimited). On release the
//               next priority start is the cell after the old winner and the
//               old winner is masked, so grants pass back-to-back when anyone
//               else is waiting.
//               MAX_HOLD : max grant cycles per tenure, 0..255
//               DELAY    : gate delay in ps handed to the grant decoder
//               clk      : rising-edge clock
//               reset_n  : synchronous active-low reset
//               arb_if   : slave side of rr_arbiter4_if (req in; gnt, gnt_id,
//                          busy, timeout out)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int          DELAY    = 50
) (
  input  logic          clk,
  input  logic          reset_n,
  rr_arbiter4_if.slave  arb_if
);

  if (MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be in 0..255");
  end

  localparam bit         c_LIMITED   = (MAX_HOLD != 0);
  localparam logic [7:0] c_HOLD_LAST = c_LIMITED ? 8'(MAX_HOLD - 1) : 8'd0;

  arb_state_t      state_q,    state_d;
  logic [IDW-1:0]  ptr_q,      ptr_d;
  logic [IDW-1:0]  id_q,       id_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic            timeout_q,  timeout_d;

  logic            own_req;
  logic            expire;
  logic            release_now;
  logic [IDW-1:0]  rel_ptr;
  logic [NREQ-1:0] own_mask;
  pick_t           pick_idle;
  pick_t           pick_rel;
  logic            busy;
  logic [IDW-1:0]  gnt_id;

  assign own_req  = arb_if.req[id_q];
  // A request dropping on the expiry cycle is an ordinary release, hence
  // expiry only counts while the owner is still requesting.
  assign expire   = c_LIMITED && own_req && (hold_cnt_q == c_HOLD_LAST);
  assign release_now = !own_req || expire;
  assign rel_ptr  = id_q + IDW'(1);
  assign own_mask = NREQ'(1) << id_q;

  assign pick_idle = rr_pick(arb_if.req, ptr_q, '0);
  // The releasing owner is masked so a timed-out requester cannot win again
  // ahead of the others.
  assign pick_rel  = rr_pick(arb_if.req, rel_ptr, own_mask);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_idle.valid) begin
          id_d       = pick_idle.id;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = rel_ptr;
          timeout_d = expire;
          if (pick_rel.valid) begin
            id_d       = pick_rel.id;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy   = (state_q == GRANT);
  // id_q keeps the last winner while idle, so it is gated here.
  assign gnt_id = busy ? id_q : '0;

  assign arb_if.busy    = busy;
  assign arb_if.gnt_id  = gnt_id;
  assign arb_if.timeout = timeout_q;

  decoder2_4 #(
    .delay (DELAY)
  ) u_gnt_dec (
    .in (gnt_id),
    .e  (busy),
    .y  (arb_if.gnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rr_arbiter4
// Description : Self-checking bench for rr_arbiter4 (MAX_HOLD = 4). Directed
//               scenarios with literal expected grant traces, then random
//               requests and occasional resets, all compared every cycle with
//               a tenure-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

  localparam int unsigned c_MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset_n;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(
    .MAX_HOLD (c_MAX_HOLD),
    .DELAY    (50)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb_if  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: who owns the resource, how many cycles it has had it,
  // and where the next scan starts.
  int m_owner  = -1;
  int m_tenure = 0;
  int m_start  = 0;
  bit m_to     = 1'b0;

  function automatic int find(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rn);
    bit own;
    bit forced;
    if (!rn) begin
      m_owner = -1; m_tenure = 0; m_start = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to     = 1'b0;
      m_owner  = find(r, m_start, -1);
      m_tenure = (m_owner >= 0) ? 1 : 0;
    end else begin
      own    = r[m_owner];
      forced = own && (c_MAX_HOLD != 0) && (m_tenure == int'(c_MAX_HOLD));
      if (!own || forced) begin
        m_start  = (m_owner + 1) % 4;
        m_owner  = find(r, m_start, m_owner);
        m_tenure = (m_owner >= 0) ? 1 : 0;
        m_to     = forced;
      end else begin
        m_tenure++;
        m_to = 1'b0;
      end
    end
  endtask

  // Apply inputs for one rising edge, then compare against the model mid-cycle.
  task automatic cycle(input logic [3:0] r, input logic rn);
    logic [3:0] e_gnt;
    bus.req = r;
    reset_n = rn;
    @(posedge clk);
    model_edge(r, rn);
    @(negedge clk);
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk("model_gnt",     32'(bus.gnt),     32'(e_gnt));
    chk("model_gnt_id",  32'(bus.gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("model_busy",    32'(bus.busy),    32'(m_owner >= 0));
    chk("model_timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
  endtask

  // Back-to-back 3-cycle tenures, requester 1 then 3 then 1.
  logic [3:0] s2_req [9]  = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010,
                              4'b1010, 4'b0010, 4'b1010, 4'b1010};
  logic [3:0] s2_gnt [9]  = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                              4'b1000, 4'b0010, 4'b0010, 4'b0010};
  // Sole requester times out, idles one cycle, is re-granted.
  logic [3:0] s3_gnt [6]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
  logic       s3_to  [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  // Request drop coinciding with expiry.
  logic [3:0] s5_req [6]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  logic [3:0] s5_gnt [6]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};

  initial begin
    logic [3:0] r;
    logic       rn;
    logic [3:0] e4;
    logic       to4;

    bus.req = 4'b0000;
    reset_n = 1'b0;

    // Reset state and idle with no requests.
    do_reset();
    chk("rst_gnt",    32'(bus.gnt),     32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id),  32'd0);
    chk("rst_busy",   32'(bus.busy),    32'd0);
    chk("rst_to",     32'(bus.timeout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 1'b1);
      chk("idle_gnt",  32'(bus.gnt),     32'd0);
      chk("idle_busy", 32'(bus.busy),    32'd0);
      chk("idle_to",   32'(bus.timeout), 32'd0);
    end

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(s2_req[i], 1'b1);
      chk("rr_1010_gnt", 32'(bus.gnt), 32'(s2_gnt[i]));
      chk("rr_1010_to",  32'(bus.timeout), 32'd0);
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(4'b0001, 1'b1);
      chk("sole_to_gnt", 32'(bus.gnt),     32'(s3_gnt[i]));
      chk("sole_to_pls", 32'(bus.timeout), 32'(s3_to[i]));
    end

    // All four requesting: 4-cycle tenures in order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(4'b1111, 1'b1);
      e4  = 4'(1 << ((i / 4) % 4));
      to4 = (i != 0) && (i % 4 == 0);
      chk("all4_gnt", 32'(bus.gnt),     32'(e4));
      chk("all4_to",  32'(bus.timeout), 32'(to4));
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(s5_req[i], 1'b1);
      chk("drop_exp_gnt", 32'(bus.gnt),     32'(s5_gnt[i]));
      chk("drop_exp_to",  32'(bus.timeout), 32'd0);
    end

    // Reset in the 2nd cycle of a grant to requester 3.
    do_reset();
    cycle(4'b1000, 1'b1);
    chk("mid_rst_g1", 32'(bus.gnt), 32'b1000);
    cycle(4'b1000, 1'b1);
    chk("mid_rst_g2", 32'(bus.gnt), 32'b1000);
    cycle(4'b1000, 1'b0);
    chk("mid_rst_gnt", 32'(bus.gnt),     32'd0);
    chk("mid_rst_to",  32'(bus.timeout), 32'd0);
    cycle(4'b1001, 1'b1);
    chk("post_rst_gnt", 32'(bus.gnt),    32'b0001);
    chk("post_rst_id",  32'(bus.gnt_id), 32'd0);

    // Random phase: sticky requests so tenures of several cycles occur.
    r = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      rn = ($urandom_range(63) != 0);
      cycle(r, rn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
